ksa_shuffle_fsm: RTL and testbench
==================================

// Module: ksa_shuffle_fsm
// PURPOSE
//  RC4 key-scheduling (KSA) shuffle engine, stage directly downstream of the key byte selector.
//  For i = 0..255 computes j = j + S[i] + key[i mod 3] and swaps S[i]/S[j] in the shared S-box RAM.
//  Drives i_counter to the key byte selector and consumes its key_byte.
//  Runs after S-init (S[i]=i) and before PRGA decrypt, under start/done control from the cracking controller.
// PARAMETERS
//  ADDR_W   8    S-box address width (256 entries)
//  DATA_W   8    S-box data width
//  KEY_W    24   secret key width (3 bytes)
// PORTS
//  clk            in   1       system clock, all state on rising edge
//  rst_n          in   1       asynchronous reset, active low
//  start          in   1       request to run the shuffle (level, sampled in IDLE)
//  secret_key_in  in   KEY_W   candidate key from cracking controller
//  done           out  1       shuffle complete; held until start deasserts
//  busy           out  1       high in every state except IDLE and DONE
//  key_latched    out  KEY_W   key captured at start; wired to selector secret_key
//  i_counter      out  8       current i; wired to selector i_counter
//  key_byte       in   8       selector output = key_latched byte (i mod 3)
//  s_address      out  ADDR_W  S-box RAM address
//  s_data         out  DATA_W  S-box RAM write data
//  s_wren         out  1       S-box RAM write enable
//  s_q            in   DATA_W  S-box RAM read data, valid the cycle after address is registered
// BEHAVIOUR
//  Reset: state IDLE; i, j, si, sj, key_latched = 0; done, busy, s_wren = 0; s_address, s_data = 0.
//  IDLE: start=1 -> latch secret_key_in, i=0, j=0, go RD_I. start=0 -> stay.
//  Per iteration, 8 states, one cycle each, s_wren=0 except WR_I/WR_J:
//   RD_I  s_address=i
//   WT_I  hold address (RAM read latency)
//   CP_I  si<=s_q; j<=j+s_q+key_byte (mod 256, 8-bit wrap, carries dropped)
//   RD_J  s_address=j
//   WT_J  hold address
//   CP_J  sj<=s_q
//   WR_I  s_address=i, s_data=sj, s_wren=1
//   WR_J  s_address=j, s_data=si, s_wren=1; i==255 -> DONE, else i<=i+1 -> RD_I
//  DONE: done=1, busy=0; stays until start=0, then IDLE (done drops with the transition).
//  Latency: start sampled at edge E0 -> done first high 2049 cycles after E0 (256x8 + 1).
//  i==j: both writes hit the same address; final value = original S[i] (correct null swap).
//  start high while busy: ignored. secret_key_in changes while busy: ignored (key_latched used).
//  key_byte must come from the combinational selector fed by key_latched/i_counter; no extra latency.
//  i wrap: i never increments past 255; j wraps freely modulo 256.
//  Reset mid-run: immediate return to IDLE with reset values; RAM left partially shuffled;
//   controller must re-run S-init before the next start.
// STRUCTURE
//  rc4_pkg: ksa_state_t enum (IDLE,RD_I,WT_I,CP_I,RD_J,WT_J,CP_J,WR_I,WR_J,DONE),
//   constants SBOX_DEPTH=256, KEY_LEN_BYTES=3.
//  No sub-module: key byte selection remains the existing selector, instantiated beside this block
//   in the parent. Single always_ff for state/datapath, single always_comb for RAM outputs.
// TESTING
//  Bench: behavioural 256x8 RAM with 1-cycle read latency, selector instantiated, C-style KSA model.
//  1 Key 24'h000000, S=identity, start -> first writes: addr0<=0, addr0<=0 (i=j=0); i=1 j=1 null;
//    i=2 j=3: addr2<=3, addr3<=2.
//  2 Key 24'h000000, full run -> done at cycle 2049 after start; final S equals model.
//  3 Key 24'h4A3F12, full run -> final S equals model; key_latched=24'h4A3F12 throughout.
//  4 Change secret_key_in to 24'hFFFFFF at i=50 -> result still matches model for 24'h4A3F12.
//  5 Assert rst_n=0 at i=100 -> outputs zero, IDLE; re-init S, start -> restarts at i=0,j=0, matches model.
//  6 Hold start=1 after done -> done stays 1, no new RAM accesses; drop start -> IDLE next cycle.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 cracking-pipeline types and constants.
// Holds the KSA shuffle state encoding and the S-box/key geometry.
package rc4_pkg;

    localparam int SBOX_DEPTH    = 256;
    localparam int KEY_LEN_BYTES = 3;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        CP_I,
        RD_J,
        WT_J,
        CP_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

endpackage

// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling shuffle: walks i over the S-box, accumulates j and swaps S[i]/S[j].
// Each iteration takes eight cycles against a RAM with registered address and one cycle read latency.
module ksa_shuffle_fsm
    import rc4_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int KEY_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  secret_key_in,
    output logic              done,
    output logic              busy,
    output logic [KEY_W-1:0]  key_latched,
    output logic [ADDR_W-1:0] i_counter,
    input  logic [DATA_W-1:0] key_byte,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_data,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_q
);

    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(SBOX_DEPTH - 1);

    ksa_state_t        state_q, state_d;
    logic [ADDR_W-1:0] i_q, j_q;
    logic [DATA_W-1:0] si_q, sj_q;
    logic [KEY_W-1:0]  keyLatched_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            i_q          <= '0;
            j_q          <= '0;
            si_q         <= '0;
            sj_q         <= '0;
            keyLatched_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        keyLatched_q <= secret_key_in;
                        i_q          <= '0;
                        j_q          <= '0;
                    end
                end
                // j accumulates modulo 256; carries out of the byte are dropped on purpose.
                CP_I: begin
                    si_q <= s_q;
                    j_q  <= j_q + ADDR_W'(s_q) + ADDR_W'(key_byte);
                end
                CP_J: sj_q <= s_q;
                WR_J: begin
                    if (i_q != LAST_I) begin
                        i_q <= i_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RD_I;
            RD_I: state_d = WT_I;
            WT_I: state_d = CP_I;
            CP_I: state_d = RD_J;
            RD_J: state_d = WT_J;
            WT_J: state_d = CP_J;
            CP_J: state_d = WR_I;
            WR_I: state_d = WR_J;
            WR_J: state_d = (i_q == LAST_I) ? DONE : RD_I;
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The read address is held through the capture cycle so s_q stays stable when sampled.
    always_comb begin
        s_address = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: busy = 1'b0;
            RD_I, WT_I, CP_I: s_address = i_q;
            RD_J, WT_J, CP_J: s_address = j_q;
            WR_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
            end
            WR_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b0;
            end
            default: busy = 1'b0;
        endcase
    end

    assign key_latched = keyLatched_q;
    assign i_counter   = i_q;

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Bench for ksa_shuffle_fsm: behavioural 256x8 RAM, combinational key byte selector and a C-style KSA model.
module tb_ksa_shuffle_fsm;
    import rc4_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key_in = '0;
    logic        done, busy, s_wren;
    logic [23:0] key_latched;
    logic [7:0]  i_counter, key_byte, s_address, s_data;
    logic [7:0]  s_q = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ksa_shuffle_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .secret_key_in (secret_key_in),
        .done          (done),
        .busy          (busy),
        .key_latched   (key_latched),
        .i_counter     (i_counter),
        .key_byte      (key_byte),
        .s_address     (s_address),
        .s_data        (s_data),
        .s_wren        (s_wren),
        .s_q           (s_q)
    );

    // Key byte 0 is the most significant byte of the 24-bit key.
    function automatic logic [7:0] keyByteOf(input logic [23:0] key, input int idx);
        case (idx)
            0:       return key[23:16];
            1:       return key[15:8];
            default: return key[7:0];
        endcase
    endfunction

    assign key_byte = keyByteOf(key_latched, int'(i_counter) % 3);

    // RAM with registered address, one cycle read latency, and a write log for inspecting traffic.
    logic [7:0] mem [256];
    logic       initReq = 1'b0;
    int         wrCount = 0;
    logic [7:0] wrAddr [4096];
    logic [7:0] wrData [4096];

    always @(posedge clk) begin
        if (initReq) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (s_wren) begin
            mem[s_address] <= s_data;
        end
        s_q <= mem[s_address];
        if (s_wren) begin
            if (wrCount < 4096) begin
                wrAddr[wrCount] <= s_address;
                wrData[wrCount] <= s_data;
            end
            wrCount <= wrCount + 1;
        end
    end

    logic [7:0] modS [256];

    task automatic buildModel(input logic [23:0] key);
        logic [7:0] j;
        logic [7:0] t;
        j = 8'd0;
        for (int k = 0; k < 256; k++) modS[k] = 8'(k);
        for (int k = 0; k < 256; k++) begin
            j = j + modS[k] + keyByteOf(key, k % 3);
            t = modS[k];
            modS[k] = modS[j];
            modS[j] = t;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compareS(input string name, input logic [23:0] key);
        int mism;
        int firstBad;
        mism = 0;
        firstBad = -1;
        buildModel(key);
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== modS[k]) begin
                mism++;
                if (firstBad < 0) firstBad = k;
            end
        end
        if (mism != 0) $display("[TB] first differing S index %0d", firstBad);
        checkOutput(name, mism, 0);
    endtask

    task automatic initS();
        @(negedge clk);
        initReq = 1'b1;
        @(negedge clk);
        initReq = 1'b0;
    endtask

    // Starts a run and follows it to done; start is left high so DONE is held.
    task automatic applyStimulus(input logic [23:0] key, input int altAtI, input logic [23:0] altKey,
                                 output int latency, output int keyErrs, output logic startOk);
        int cycles;
        bit altDone;
        keyErrs = 0;
        altDone = 0;
        startOk = 1'b0;
        cycles  = 0;
        @(negedge clk);
        secret_key_in = key;
        start = 1'b1;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 1)
                startOk = (busy === 1'b1) && (i_counter === 8'd0) && (s_address === 8'd0) && (done === 1'b0);
            if (busy && key_latched !== key) keyErrs++;
            if (altAtI >= 0 && !altDone && int'(i_counter) == altAtI) begin
                secret_key_in = altKey;
                altDone = 1;
            end
        end while (!done && cycles < 3000);
        latency = done ? cycles : -1;
    endtask

    task automatic endRun();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wrVec_t;

    wrVec_t firstWrites [6];

    initial begin
        int lat, kerr, base, doneErr, n;
        logic sok;

        // Key 0 over identity S: i=0,j=0 null; i=1,j=1 null; i=2,j=3 swaps 2 and 3.
        firstWrites[0] = '{addr: 8'd0, data: 8'd0};
        firstWrites[1] = '{addr: 8'd0, data: 8'd0};
        firstWrites[2] = '{addr: 8'd1, data: 8'd1};
        firstWrites[3] = '{addr: 8'd1, data: 8'd1};
        firstWrites[4] = '{addr: 8'd2, data: 8'd3};
        firstWrites[5] = '{addr: 8'd3, data: 8'd2};

        #2;
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wren", s_wren, 0);
        checkOutput("rst_addr", s_address, 0);
        checkOutput("rst_data", s_data, 0);
        checkOutput("rst_key", key_latched, 0);
        checkOutput("rst_i", i_counter, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Key 0: first writes, latency, full result.
        initS();
        base = wrCount;
        applyStimulus(24'h000000, -1, 24'h0, lat, kerr, sok);
        checkOutput("k0_start_state", sok, 1);
        checkOutput("k0_latency", lat, 2049);
        checkOutput("k0_key_latched", kerr, 0);
        checkOutput("k0_write_count", wrCount - base, 512);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("k0_wr%0d_addr", k), wrAddr[base + k], firstWrites[k].addr);
            checkOutput($sformatf("k0_wr%0d_data", k), wrData[base + k], firstWrites[k].data);
        end
        compareS("k0_final_S", 24'h000000);
        endRun();

        // Key 4A3F12 plain run.
        initS();
        applyStimulus(24'h4A3F12, -1, 24'h0, lat, kerr, sok);
        checkOutput("k1_latency", lat, 2049);
        checkOutput("k1_key_latched", kerr, 0);
        compareS("k1_final_S", 24'h4A3F12);
        endRun();

        // Key input changes mid-run must not affect the result.
        initS();
        applyStimulus(24'h4A3F12, 50, 24'hFFFFFF, lat, kerr, sok);
        checkOutput("k2_latency", lat, 2049);
        checkOutput("k2_key_latched", kerr, 0);
        compareS("k2_final_S", 24'h4A3F12);

        // start held after done: DONE persists with no RAM traffic, then drops to IDLE.
        base = wrCount;
        doneErr = 0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b1 || busy !== 1'b0 || s_wren !== 1'b0) doneErr++;
        end
        checkOutput("hold_done", doneErr, 0);
        checkOutput("hold_no_writes", wrCount - base, 0);
        start = 1'b0;
        @(negedge clk);
        checkOutput("drop_done", done, 0);
        checkOutput("drop_busy", busy, 0);
        @(negedge clk);

        // Reset in the middle of a run.
        initS();
        @(negedge clk);
        secret_key_in = 24'h4A3F12;
        start = 1'b1;
        n = 0;
        while (i_counter != 8'd100 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_reach_i100", i_counter, 100);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_wren", s_wren, 0);
        checkOutput("mid_rst_addr", s_address, 0);
        checkOutput("mid_rst_data", s_data, 0);
        checkOutput("mid_rst_i", i_counter, 0);
        checkOutput("mid_rst_key", key_latched, 0);
        @(negedge clk);
        rst_n = 1'b1;
        initS();
        applyStimulus(24'h4A3F12, -1, 24'h0, lat, kerr, sok);
        checkOutput("rerun_start_state", sok, 1);
        checkOutput("rerun_latency", lat, 2049);
        compareS("rerun_final_S", 24'h4A3F12);
        endRun();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
